// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: owns the fetch PC, issues one cache word request at a
// time, buffers returned words with their PC toward decode, and applies redirects.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        imem_err,
    output logic        out_valid,
    output logic [31:0] out_pc,
    output logic [31:0] out_instr,
    output logic        out_fault,
    input  logic        out_ready
);

    localparam int unsigned PW  = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int unsigned CW  = $clog2(QDEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DRAIN,
        S_HALT
    } state_t;

    state_t          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic [31:0]     req_pc_q, req_pc_d;
    logic            imem_req_q, imem_req_d;
    logic            enq, flush, deq, head_is_new;

    logic [CW-1:0]   count_q, count_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [31:0]     q_pc    [QDEPTH];
    logic [31:0]     q_instr [QDEPTH];
    logic            q_fault [QDEPTH];

    logic            out_valid_q, out_valid_d;
    logic [31:0]     out_pc_q, out_pc_d;
    logic [31:0]     out_instr_q, out_instr_d;
    logic            out_fault_q, out_fault_d;

    // Redirect targets are halfword aligned; the LSB is discarded.
    logic            unused_redirect_lsb;
    assign unused_redirect_lsb = redirect_pc[0];

    assign imem_req  = imem_req_q;
    assign imem_addr = {fetch_pc_q[31:2], 2'b00};
    assign out_valid = out_valid_q;
    assign out_pc    = out_pc_q;
    assign out_instr = out_instr_q;
    assign out_fault = out_fault_q;

    // Next-state, fetch PC and enqueue decision; redirect overrides everything but IDLE.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        enq        = 1'b0;
        flush      = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (imem_req_q && imem_gnt) begin
                    req_pc_d   = fetch_pc_q;
                    fetch_pc_d = {fetch_pc_q[31:2], 2'b00} + 32'd4;
                    state_d    = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    enq     = 1'b1;
                    state_d = imem_err ? S_HALT : S_REQ;
                end
            end
            S_DRAIN: begin
                if (imem_rvalid) begin
                    state_d = S_REQ;
                end
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid && (state_q != S_IDLE)) begin
            flush      = 1'b1;
            enq        = 1'b0;
            fetch_pc_d = {redirect_pc[31:1], 1'b0};
            case (state_q)
                S_REQ:           state_d = (imem_req_q && imem_gnt) ? S_DRAIN : S_REQ;
                S_WAIT, S_DRAIN: state_d = imem_rvalid ? S_REQ : S_DRAIN;
                default:         state_d = S_REQ;
            endcase
        end
    end

    // Queue pointers, occupancy, registered head and request gating on free space.
    always_comb begin
        deq         = out_valid_q && out_ready;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        head_is_new = 1'b0;
        out_pc_d    = out_pc_q;
        out_instr_d = out_instr_q;
        out_fault_d = out_fault_q;
        if (flush) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (enq) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d     = count_q + CW'(enq) - CW'(deq);
            head_is_new = enq && ((count_q - CW'(deq)) == '0);
        end
        out_valid_d = (count_d != '0);
        if (out_valid_d) begin
            if (head_is_new) begin
                out_pc_d    = req_pc_q;
                out_instr_d = imem_rdata;
                out_fault_d = imem_err;
            end else begin
                out_pc_d    = q_pc[rd_ptr_d];
                out_instr_d = q_instr[rd_ptr_d];
                out_fault_d = q_fault[rd_ptr_d];
            end
        end
        imem_req_d = (state_d == S_REQ) && (count_d < CW'(QDEPTH));
    end

    // Control and head registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            imem_req_q  <= 1'b0;
            count_q     <= '0;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_instr_q <= NOP;
            out_fault_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            imem_req_q  <= imem_req_d;
            count_q     <= count_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_instr_q <= out_instr_d;
            out_fault_q <= out_fault_d;
        end
    end

    // Queue storage, written at the tail on enqueue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(QDEPTH); i++) begin
                q_pc[i]    <= '0;
                q_instr[i] <= NOP;
                q_fault[i] <= 1'b0;
            end
        end else if (enq) begin
            q_pc[wr_ptr_q]    <= req_pc_q;
            q_instr[wr_ptr_q] <= imem_rdata;
            q_fault[wr_ptr_q] <= imem_err;
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: directed stimulus queues expected requests and
// decode entries; a forked monitor pops and compares on each handshake.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_fault;
    logic        out_ready;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        fault;
    } out_exp_t;

    logic [31:0] req_q[$];
    out_exp_t    out_q[$];
    int          checks = 0;
    int          errors = 0;
    int          fv;

    fetch_sequencer #(.RESET_PC(32'h0000_0000), .QDEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
        .out_valid(out_valid), .out_pc(out_pc), .out_instr(out_instr),
        .out_fault(out_fault), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1234_5678;
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic exp_req(input logic [31:0] a);
        req_q.push_back(a);
    endtask

    task automatic exp_out(input logic [31:0] pc, input logic [31:0] instr, input logic fault);
        out_q.push_back('{pc: pc, instr: instr, fault: fault});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Cache responder: answers each grant with a word one cycle later.
    task automatic run_cycles(input int n, input bit auto_rsp, output int first_valid);
        bit          hs;
        logic [31:0] a;
        first_valid = -1;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (out_valid && first_valid < 0) first_valid = i;
            hs = auto_rsp && imem_req && imem_gnt;
            a  = imem_addr;
            @(posedge clk);
            #1;
            imem_rvalid = hs;
            imem_rdata  = hs ? word_of(a) : 32'h0;
            imem_err    = 1'b0;
        end
    endtask

    task automatic check_reset_values(input string tag);
        check32({tag, "_req"},   32'(imem_req),  32'd0);
        check32({tag, "_addr"},  imem_addr,      32'h0000_0000);
        check32({tag, "_valid"}, 32'(out_valid), 32'd0);
        check32({tag, "_pc"},    out_pc,         32'h0000_0000);
        check32({tag, "_instr"}, out_instr,      32'h0000_0013);
        check32({tag, "_fault"}, 32'(out_fault), 32'd0);
    endtask

    // Pops expectations on every request handshake and every decode handshake.
    task automatic monitor;
        logic [31:0] ea;
        out_exp_t    eo;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (imem_req && imem_gnt) begin
                    if (req_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_req: got addr %h expected no request", imem_addr);
                    end else begin
                        ea = req_q.pop_front();
                        check32("imem_addr", imem_addr, ea);
                    end
                end
                if (out_valid && out_ready) begin
                    if (out_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_out: got pc %h expected no entry", out_pc);
                    end else begin
                        eo = out_q.pop_front();
                        check32("out_pc",    out_pc,         eo.pc);
                        check32("out_instr", out_instr,      eo.instr);
                        check32("out_fault", 32'(out_fault), 32'(eo.fault));
                    end
                end
            end
        end
    endtask

    initial begin
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = 32'h0;
        imem_err       = 1'b0;
        out_ready      = 1'b0;

        fork
            monitor();
            begin
                #100000;
                $display("FAIL watchdog: got timeout expected completion");
                $fatal(1, "watchdog");
            end
        join_none

        repeat (2) tick;
        @(negedge clk);
        check_reset_values("reset");
        tick;

        // Streaming fetch after reset release.
        reset     = 1'b0;
        out_ready = 1'b1;
        imem_gnt  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_req(32'(k * 4));
            exp_out(32'(k * 4), word_of(32'(k * 4)), 1'b0);
        end
        run_cycles(8, 1'b1, fv);
        check32("first_valid_edges", 32'(fv - 1), 32'd3);
        imem_gnt = 1'b0;
        run_cycles(2, 1'b1, fv);

        // Back-pressure: queue fills to two, request withheld.
        out_ready = 1'b0;
        imem_gnt  = 1'b1;
        exp_req(32'd16); exp_req(32'd20); exp_req(32'd24);
        exp_out(32'd16, word_of(32'd16), 1'b0);
        exp_out(32'd20, word_of(32'd20), 1'b0);
        exp_out(32'd24, word_of(32'd24), 1'b0);
        run_cycles(8, 1'b1, fv);
        @(negedge clk);
        check32("full_req_low", 32'(imem_req),  32'd0);
        check32("full_valid",   32'(out_valid), 32'd1);
        check32("full_head_pc", out_pc,         32'd16);
        tick;
        out_ready = 1'b1;
        run_cycles(1, 1'b1, fv);
        out_ready = 1'b0;
        run_cycles(1, 1'b1, fv);
        run_cycles(3, 1'b1, fv);
        check32("one_new_req_only", 32'(imem_req), 32'd0);
        imem_gnt  = 1'b0;
        out_ready = 1'b1;
        run_cycles(3, 1'b1, fv);

        // Redirect while waiting; stale response drained.
        exp_req(32'd28);
        imem_gnt = 1'b1;
        tick;
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        tick;
        redirect_valid = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        @(negedge clk);
        check32("drain_req_low", 32'(imem_req),  32'd0);
        check32("drain_flushed", 32'(out_valid), 32'd0);
        tick;
        imem_rvalid = 1'b0;
        @(negedge clk);
        check32("stale_dropped", 32'(out_valid), 32'd0);
        check32("redir_req",     32'(imem_req),  32'd1);
        check32("redir_addr",    imem_addr,      32'h0000_1000);
        tick;
        exp_req(32'h0000_1000);
        exp_out(32'h0000_1002, word_of(32'h0000_1000), 1'b0);
        imem_gnt = 1'b1;
        run_cycles(2, 1'b1, fv);
        imem_gnt = 1'b0;
        run_cycles(2, 1'b1, fv);

        // Redirect coincident with the response: word dropped.
        exp_req(32'h0000_1004);
        imem_gnt = 1'b1;
        tick;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h0BAD_0BAD;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        tick;
        imem_rvalid    = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        check32("coinc_no_enq", 32'(out_valid), 32'd0);
        check32("coinc_req",    32'(imem_req),  32'd1);
        check32("coinc_addr",   imem_addr,      32'h0000_2000);
        tick;
        exp_req(32'h0000_2000);
        exp_out(32'h0000_2000, word_of(32'h0000_2000), 1'b0);
        imem_gnt = 1'b1;
        run_cycles(2, 1'b1, fv);
        imem_gnt = 1'b0;
        run_cycles(2, 1'b1, fv);

        // Fetch fault halts fetching until a redirect.
        exp_req(32'h0000_2004);
        exp_out(32'h0000_2004, 32'hFA17_0000, 1'b1);
        imem_gnt = 1'b1;
        tick;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hFA17_0000;
        imem_err    = 1'b1;
        tick;
        imem_rvalid = 1'b0;
        imem_err    = 1'b0;
        imem_rdata  = 32'h0;
        imem_gnt    = 1'b1;
        run_cycles(4, 1'b1, fv);
        @(negedge clk);
        check32("halt_req_low", 32'(imem_req), 32'd0);
        tick;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_3000;
        tick;
        redirect_valid = 1'b0;
        exp_req(32'h0000_3000);
        exp_out(32'h0000_3000, word_of(32'h0000_3000), 1'b0);
        run_cycles(2, 1'b1, fv);
        imem_gnt = 1'b0;
        run_cycles(2, 1'b1, fv);

        // Address wrap at the top of memory.
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick;
        redirect_valid = 1'b0;
        exp_req(32'hFFFF_FFFC);
        exp_req(32'h0000_0000);
        exp_out(32'hFFFF_FFFC, word_of(32'hFFFF_FFFC), 1'b0);
        exp_out(32'h0000_0000, word_of(32'h0000_0000), 1'b0);
        imem_gnt = 1'b1;
        run_cycles(4, 1'b1, fv);
        imem_gnt = 1'b0;
        run_cycles(2, 1'b1, fv);

        // Reset while waiting; late response ignored.
        exp_req(32'h0000_0004);
        imem_gnt = 1'b1;
        tick;
        imem_gnt = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        check_reset_values("midreset");
        tick;
        reset       = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_0055;
        tick;
        imem_rvalid = 1'b0;
        @(negedge clk);
        check32("late_rvalid_ignored", 32'(out_valid), 32'd0);
        check32("post_reset_req",      32'(imem_req),  32'd1);
        check32("post_reset_addr",     imem_addr,      32'h0000_0000);
        tick;
        @(negedge clk);
        check32("late_rvalid_still", 32'(out_valid), 32'd0);

        check32("req_q_drained", 32'(req_q.size()), 32'd0);
        check32("out_q_drained", 32'(out_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
